fetch_controller: RTL and testbench

Sequences the instruction-fetch datapath: owns the program counter, issues requests to the synchronous instruction memory, and buffers returned instructions toward decode with a valid/ready handshake. Applies branch/jump redirects and squashes wrong-path fetches. Sits between the PC/adder/instruction-memory datapath and the IF/ID boundary.

---
 rtl/fetch_controller_pkg.sv | 23 ++
 rtl/adder.sv | 12 +
 rtl/fetch_return_buffer.sv | 64 ++++++
 rtl/fetch_controller.sv | 148 ++++++++++++++
 tb/tb_fetch_controller.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_controller_pkg;

  // Sequencing states of the fetch controller
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INST_BYTES      = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // A return-buffer entry is {pc, instruction}
  localparam int unsigned BUF_ENTRY_W = 64;

  // Clear the byte offset so redirect targets always land on an instruction boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational WIDTH-bit adder, carry out discarded (wraps)
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_return_buffer.sv
// rtl/fetch_return_buffer.sv - two-entry FIFO between instruction memory and decode
module fetch_return_buffer
  import fetch_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_tvalid,
  input  logic [BUF_ENTRY_W-1:0] push_tdata,
  output logic                   head_tvalid,
  input  logic                   head_tready,
  output logic [BUF_ENTRY_W-1:0] head_tdata,
  output logic [1:0]             occ
);

  logic [BUF_ENTRY_W-1:0] entry0;
  logic [BUF_ENTRY_W-1:0] entry1;
  logic                   pop;

  assign head_tvalid = (occ != 2'd0);
  assign head_tdata  = entry0;
  assign pop         = head_tvalid & head_tready;

  // Entry 0 is always the head; a pop shifts entry 1 forward, flush drops everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ    <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      unique case ({push_tvalid, pop})
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            entry0 <= push_tdata;
          end else begin
            entry1 <= push_tdata;
          end
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            entry0 <= push_tdata;
          end else begin
            entry0 <= entry1;
            entry1 <= push_tdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The controller only issues when a slot is guaranteed, so a push into a full buffer is a bug
  assert property (@(posedge clk) disable iff (!rst)
    !(push_tvalid && !pop && !flush && occ == 2'd2));

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - program counter, instruction memory requests and decode-side buffering
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] fetch_count
);

  fetch_state_t           state;
  logic [31:0]            pc;
  logic [31:0]            pc_plus4;
  logic [31:0]            resp_pc;
  logic [31:0]            redirect_pc;
  logic                   inflight;
  logic                   kill;
  logic                   halted;
  logic                   halt_any;
  logic                   redirect;
  logic                   pop;
  logic                   push;
  logic                   room;
  logic                   issue_ok;
  logic [2:0]             pending;
  logic [1:0]             occ;
  logic [BUF_ENTRY_W-1:0] head_tdata;

  // Branch comes from EX and is older than a jump in ID, so it wins
  assign redirect    = branch_taken | jump;
  assign redirect_pc = word_align(branch_taken ? branch_target : jump_target);
  assign halt_any    = halt | halted;

  // Slots already committed: buffered entries plus the response in flight, less this cycle's pop
  assign pop     = id_valid & id_ready;
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign room    = pending < 3'(BUF_DEPTH);

  // REDIRECT always fetches its target once, even when halted; RUN fetches only while not halted
  assign issue_ok  = (state == REDIRECT) || ((state == RUN) && !halt_any);
  assign imem_req  = issue_ok & ~redirect & room;
  assign imem_addr = pc;

  // A response arriving in or right after a redirect cycle belongs to the squashed path
  assign push = inflight & ~kill & ~redirect;

  assign id_pc   = head_tdata[63:32];
  assign id_inst = head_tdata[31:0];

  adder #(.WIDTH(32)) u_pc_adder (
    .a   (pc),
    .b   (INST_BYTES),
    .sum (pc_plus4)
  );

  fetch_return_buffer u_return_buffer (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect),
    .push_tvalid (push),
    .push_tdata  ({resp_pc, imem_rdata}),
    .head_tvalid (id_valid),
    .head_tready (id_ready),
    .head_tdata  (head_tdata),
    .occ         (occ)
  );

  // Fetch sequencing: one boot cycle, then run/redirect/halt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      unique case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            state <= REDIRECT;
          end else if (halt_any) begin
            state <= HALTED;
          end
        end
        REDIRECT: begin
          if (redirect) begin
            state <= REDIRECT;
          end else if (halt_any) begin
            state <= HALTED;
          end else begin
            state <= RUN;
          end
        end
        HALTED: begin
          if (redirect) begin
            state <= REDIRECT;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // PC, in-flight tracking, sticky halt and delivered-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= word_align(RESET_PC);
      resp_pc     <= 32'd0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      inflight <= imem_req;
      kill     <= redirect;
      if (imem_req) begin
        resp_pc <= pc;
      end
      if (redirect) begin
        pc <= redirect_pc;
      end else if (imem_req) begin
        pc <= pc_plus4;
      end
      if (halt) begin
        halted <= 1'b1;
      end
      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized bench for fetch_controller against a queue-based reference model
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_controller #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .fetch_count   (fetch_count)
  );

  // memory environment: answers the previous cycle's request
  logic        env_req_q;
  logic [31:0] env_addr_q;

  // reference model: program order as a queue of PCs plus a single in-flight slot
  bit          m_boot;
  bit          m_halted;
  bit          m_redir;
  bit          m_flight;
  logic [31:0] m_flight_pc;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic [31:0] m_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr | 32'hA000_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_init();
    m_boot      = 1'b1;
    m_halted    = 1'b0;
    m_redir     = 1'b0;
    m_flight    = 1'b0;
    m_flight_pc = 32'd0;
    m_pc        = 32'd0;
    m_count     = 32'd0;
    m_q.delete();
    env_req_q   = 1'b0;
    env_addr_q  = 32'd0;
  endtask

  task automatic drive_idle();
    halt          = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jump          = 1'b0;
    jump_target   = 32'd0;
    id_ready      = 1'b0;
    imem_rdata    = 32'd0;
  endtask

  // one clock cycle: drive inputs, compare outputs with the model, advance the model
  task automatic step(input bit br, input logic [31:0] bt, input bit jp, input logic [31:0] jt,
                      input bit hl, input bit rdy);
    bit redir;
    bit pop;
    bit may_issue;
    bit exp_req;
    int pending;
    @(negedge clk);
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    halt          = hl;
    id_ready      = rdy;
    imem_rdata    = env_req_q ? mem_word(env_addr_q) : $urandom;
    #1;
    redir     = br | jp;
    pop       = (m_q.size() != 0) && rdy;
    pending   = m_q.size() + int'(m_flight) - int'(pop);
    may_issue = !m_boot && (m_redir || !(m_halted || hl));
    exp_req   = may_issue && !redir && (pending < 2);

    check_eq("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("id_pc", id_pc, m_q[0]);
      check_eq("id_inst", id_inst, mem_word(m_q[0]));
    end
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("fetch_count", fetch_count, m_count);

    env_req_q  = imem_req;
    env_addr_q = imem_addr;

    if (pop) m_count = m_count + 32'd1;
    if (redir) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_flight) m_q.push_back(m_flight_pc);
    end
    m_flight    = exp_req;
    m_flight_pc = m_pc;
    if (redir) m_pc = (br ? bt : jt) & ~32'h3;
    else if (exp_req) m_pc = m_pc + 32'd4;
    m_halted = m_halted | hl;
    m_redir  = redir;
    m_boot   = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, rdy);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      bit br;
      bit jp;
      br = ($urandom_range(0, 15) == 0);
      jp = ($urandom_range(0, 11) == 0);
      step(br, $urandom_range(0, 32'hFFF), jp, $urandom_range(0, 32'hFFF), 1'b0,
           ($urandom_range(0, 3) != 0));
    end
  endtask

  // asynchronous reset in the middle of a cycle, checked before any clock edge
  task automatic pulse_reset();
    #2;
    rst = 1'b0;
    drive_idle();
    #1;
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_fetch_count", fetch_count, 32'd0);
    check_eq("rst_id_pc", id_pc, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_init();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    model_init();
    @(posedge clk);
    #1;
    check_eq("reset_id_valid", 32'(id_valid), 32'd0);
    check_eq("reset_imem_req", 32'(imem_req), 32'd0);
    check_eq("reset_id_pc", id_pc, 32'd0);
    check_eq("reset_id_inst", id_inst, 32'd0);
    check_eq("reset_fetch_count", fetch_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // steady stream from reset
    run_stream(12, 1'b1);
    // decode stalls, buffer fills, then resumes
    run_stream(5, 1'b0);
    run_stream(6, 1'b1);
    // jump to an unaligned target
    step(1'b0, 32'd0, 1'b1, 32'h0000_0103, 1'b0, 1'b1);
    run_stream(6, 1'b1);
    // branch and jump together: branch wins
    step(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0, 1'b1);
    run_stream(6, 1'b1);
    // redirect while decode is stalled on a held instruction
    run_stream(3, 1'b0);
    step(1'b0, 32'd0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    run_stream(5, 1'b1);
    // random traffic
    run_random(400);

    // asynchronous reset mid-stream, then restart
    run_stream(4, 1'b1);
    pulse_reset();
    run_stream(8, 1'b1);
    run_random(300);

    // halt with a request in flight, then a redirect while halted
    run_stream(4, 1'b1);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    run_stream(8, 1'b1);
    step(1'b1, 32'h0000_0080, 1'b0, 32'd0, 1'b0, 1'b1);
    run_stream(8, 1'b1);
    run_random(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
